bf_lut_pipe: RTL and testbench
==============================

Name: bf_lut_pipe

Overview:
- Parametrised, registered successor to the single-bit 3-input Boolean function block.
- Evaluates a programmable 3-input truth table independently on each of WIDTH bit lanes.
- Output is registered behind a valid/ready handshake.
- Keeps a saturating count of asserted output bits. It sits between the lab's stimulus source (switches or a testbench driver) and downstream display or check logic.

Parameters:
WIDTH, 8, number of independent bit lanes (1..64)
CNT_W, 16, width of the hit counter
LUT_RST, 8'h15, truth table loaded at reset; 8'h15 reproduces x = (~a|~b)&~c

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
cfg_we  input  1  load cfg_lut into the LUT register this cycle
cfg_lut  input  8  truth table; bit index = {a,b,c}
cnt_clr  input  1  synchronous clear of hit_cnt
in_valid  input  1  a/b/c carry a valid vector
in_ready  output  1  block can accept a vector this cycle
a  input  WIDTH  lane operand a
b  input  WIDTH  lane operand b
c  input  WIDTH  lane operand c
out_valid  output  1  x holds a valid result
out_ready  input  1  consumer accepts x this cycle
x  output  WIDTH  per-lane result, x[i] = lut[{a[i],b[i],c[i]}]
hit_cnt  output  CNT_W  saturating sum of popcount(x) over accepted outputs
lut  output  8  current truth table (read-back)

Behaviour:
- Reset (rst_n low at a clk edge):
  - lut=LUT_RST, out_valid=0, x=0, hit_cnt=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-transfer discards any held result. There is no partial output.
- Handshake:
  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
  - in_ready = ~out_valid | out_ready. This is combinational from out_ready; there is no combinational path from in_valid.
  - The block is a single-entry pipeline register with latency 1: a vector accepted at edge N appears on x with out_valid=1 after edge N.
  - Full throughput: when out_ready is held high, one vector per cycle.
  - If in_fire: x <= f(a,b,c), out_valid <= 1.
  - Else if out_fire: out_valid <= 0 and x holds its last value.
  - Else: hold.
  - While out_valid=1 and out_ready=0, x and out_valid are stable and in_ready=0 (backpressure).
- LUT update:
  - On cfg_we the lut register loads cfg_lut at the edge.
  - An input accepted in the same cycle as cfg_we is evaluated with the OLD lut.
  - A result already held in x is never re-evaluated.
- Hit counter:
  - On out_fire, hit_cnt <= min(hit_cnt + popcount(x), 2^CNT_W - 1). The popcount width is $clog2(WIDTH+1), zero-extended before the add.
  - cnt_clr has priority over increment: with cnt_clr=1, hit_cnt <= 0 even if out_fire.
  - Saturation holds until cnt_clr or reset.
- No state machine beyond out_valid. Both states (EMPTY: out_valid=0; FULL: out_valid=1) are fully described by the rules above.

Decomposition:
- Shared package bf_pkg holds:
  - LUT_W=8
  - the reset constant LUT_BF_DEFAULT=8'h15
  - the helper function lut3(lut, a, b, c) returning one bit
- One natural sub-module: bf_lane. It is a purely combinational 1-bit LUT lookup, instantiated WIDTH times via generate.
- Popcount is a function inside bf_lut_pipe, not a module.

Test Plan:
- Reset default, WIDTH=8, out_ready=1: a=8'hF0, b=8'hCC, c=8'hAA, one in_valid pulse. One cycle later, out_valid=1 and x=8'h15, i.e. x = (~a|~b)&~c; hit_cnt=3 after the following edge.
- Backpressure: send two vectors with out_ready=0. in_ready drops after the first is accepted and x stays stable for 5 cycles. Raise out_ready: the first result is consumed and the second is accepted and output on the next cycle, with no loss or duplication.
- LUT reprogram: in one cycle assert cfg_we with cfg_lut=8'h80 (3-input AND) together with in_fire of a=b=c=8'hFF. x=8'h00 (old LUT), and lut reads 8'h80 afterwards. Resending the same vector gives x=8'hFF.
- Saturation: CNT_W=4, LUT=8'hFF (all-ones), out_ready=1, stream 3 vectors. hit_cnt goes 8 -> 15 -> 15.
- Clear priority: assert cnt_clr in the same cycle as out_fire with x=8'hFF. hit_cnt=0, not 8.
- Mid-operation reset: with out_valid=1 and out_ready=0, pull rst_n low for one edge. out_valid=0, x=0, hit_cnt=0, lut=8'h15 and in_ready=1 on the next cycle.

Source files
------------

// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared constants and LUT helper for the bit-lane function pipe
// Contents: LUT_W (truth-table width), LUT_BF_DEFAULT (reset table), lut3() lookup.
package bf_pkg;

    localparam int LUT_W = 8;

    // 8'h15 selects {a,b,c} = 000, 010, 100, which is x = (~a | ~b) & ~c
    localparam logic [LUT_W-1:0] LUT_BF_DEFAULT = 8'h15;

    // Truth-table index is {a,b,c} with a as the MSB
    function automatic logic lut3(input logic [LUT_W-1:0] lut,
                                  input logic a, input logic b, input logic c);
        return lut[{a, b, c}];
    endfunction

endpackage

// File: rtl/bf_lane.sv
// rtl/bf_lane.sv - combinational single-bit 3-input truth-table lookup
// Ports: i_lut (truth table), i_a/i_b/i_c (lane operands), o_x (lane result).
module bf_lane
    import bf_pkg::*;
(
    input  logic [LUT_W-1:0] i_lut,
    input  logic             i_a,
    input  logic             i_b,
    input  logic             i_c,
    output logic             o_x
);

    assign o_x = lut3(i_lut, i_a, i_b, i_c);

endmodule

// File: rtl/bf_lut_pipe.sv
// rtl/bf_lut_pipe.sv - registered WIDTH-lane programmable 3-input function with hit counter
// Ports: clk, rst_n (sync, active low); cfg_we/cfg_lut load the truth table; cnt_clr
// clears hit_cnt; in_valid/in_ready with a/b/c form the input handshake; out_valid/
// out_ready with x form the output handshake; hit_cnt is the saturating popcount sum
// of consumed results; lut reads back the current truth table.
module bf_lut_pipe
    import bf_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               CNT_W   = 16,
    parameter logic [LUT_W-1:0] LUT_RST = LUT_BF_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [LUT_W-1:0] cfg_lut,
    input  logic             cnt_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [LUT_W-1:0] lut
);

    localparam int PC_W  = $clog2(WIDTH + 1);
    // One spare bit above the wider operand so the overflow is visible before clamping
    localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    logic [LUT_W-1:0] r_lut;
    logic             r_valid;
    logic [WIDTH-1:0] r_x;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_x;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [SUM_W-1:0] w_sum;

    // Lanes read the registered table, so a vector accepted alongside cfg_we sees the old LUT
    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        bf_lane u_lane (
            .i_lut (r_lut),
            .i_a   (a[g]),
            .i_b   (b[g]),
            .i_c   (c[g]),
            .o_x   (w_x[g])
        );
    end

    // Single-entry slot: free when empty or when the held result leaves this cycle
    assign in_ready   = ~r_valid | out_ready;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_valid & out_ready;
    assign w_sum      = SUM_W'(r_cnt) + SUM_W'(popcount(r_x));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lut   <= LUT_RST;
            r_valid <= 1'b0;
            r_x     <= '0;
            r_cnt   <= '0;
        end else begin
            if (cfg_we) begin
                r_lut <= cfg_lut;
            end

            if (w_in_fire) begin
                r_x     <= w_x;
                r_valid <= 1'b1;
            end else if (w_out_fire) begin
                r_valid <= 1'b0;
            end

            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (w_out_fire) begin
                r_cnt <= (w_sum > CNT_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
            end
        end
    end

    assign out_valid = r_valid;
    assign x         = r_x;
    assign hit_cnt   = r_cnt;
    assign lut       = r_lut;

endmodule

// File: tb/tb_bf_lut_pipe.sv
// tb/tb_bf_lut_pipe.sv - directed table-driven bench for bf_lut_pipe
module tb_bf_lut_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [7:0]  cfg_lut;
    logic        cnt_clr;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  a, b, c;

    logic        in_ready, out_valid;
    logic [7:0]  x, lut;
    logic [15:0] hit_cnt;

    logic        s_in_ready, s_out_valid;
    logic [7:0]  s_x, s_lut;
    logic [3:0]  s_hit_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bf_lut_pipe dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_lut(cfg_lut), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c(c),
        .out_valid(out_valid), .out_ready(out_ready), .x(x), .hit_cnt(hit_cnt), .lut(lut)
    );

    bf_lut_pipe #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_lut(cfg_lut), .cnt_clr(cnt_clr),
        .in_valid(in_valid), .in_ready(s_in_ready), .a(a), .b(b), .c(c),
        .out_valid(s_out_valid), .out_ready(out_ready), .x(s_x), .hit_cnt(s_hit_cnt),
        .lut(s_lut)
    );

    typedef struct {
        logic [7:0] tbl_lut;
        logic [7:0] va, vb, vc;
        logic [7:0] exp_x;
    } vec_t;

    vec_t tbl [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic program_lut(input logic [7:0] v);
        cfg_we  = 1'b1;
        cfg_lut = v;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic clear_cnt();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'h80, 8'hF0, 8'hCC, 8'hAA, 8'h80};
        tbl[1] = '{8'hFE, 8'hF0, 8'hCC, 8'hAA, 8'hFE};
        tbl[2] = '{8'h96, 8'hF0, 8'hCC, 8'hAA, 8'h96};
        tbl[3] = '{8'hE8, 8'hF0, 8'hCC, 8'hAA, 8'hE8};
        tbl[4] = '{8'hF0, 8'h5A, 8'h33, 8'h0F, 8'h5A};
        tbl[5] = '{8'hCC, 8'h5A, 8'h33, 8'h0F, 8'h33};
        tbl[6] = '{8'hAA, 8'h5A, 8'h33, 8'h0F, 8'h0F};
        tbl[7] = '{8'h15, 8'hFF, 8'h00, 8'h00, 8'hFF};
        tbl[8] = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h00};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_lut = 8'h00; cnt_clr = 1'b0;
        in_valid = 1'b0; out_ready = 1'b1; a = 8'h00; b = 8'h00; c = 8'h00;
        tick();
        tick();
        rst_n = 1'b1;

        // reset state
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_x", 64'(x), 64'(0));
        chk("rst_hit_cnt", 64'(hit_cnt), 64'(0));
        chk("rst_lut", 64'(lut), 64'h15);
        chk("rst_in_ready", 64'(in_ready), 64'(1));

        // default function, single pulse
        a = 8'hF0; b = 8'hCC; c = 8'hAA; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("dflt_out_valid", 64'(out_valid), 64'(1));
        chk("dflt_x", 64'(x), 64'h15);
        tick();
        chk("dflt_hit_cnt", 64'(hit_cnt), 64'(3));
        chk("dflt_drained", 64'(out_valid), 64'(0));
        chk("dflt_x_hold", 64'(x), 64'h15);

        // table of truth tables
        for (int i = 0; i < 9; i++) begin
            program_lut(tbl[i].tbl_lut);
            chk($sformatf("tbl%0d_lut", i), 64'(lut), 64'(tbl[i].tbl_lut));
            a = tbl[i].va; b = tbl[i].vb; c = tbl[i].vc; in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            chk($sformatf("tbl%0d_x", i), 64'(x), 64'(tbl[i].exp_x));
            tick();
        end

        // backpressure
        program_lut(8'h15);
        clear_cnt();
        out_ready = 1'b0;
        a = 8'hF0; b = 8'hCC; c = 8'hAA; in_valid = 1'b1;
        tick();
        a = 8'hFF; b = 8'h00; c = 8'h00;
        chk("bp_in_ready_low", 64'(in_ready), 64'(0));
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_hold%0d_x", k), 64'(x), 64'h15);
            chk($sformatf("bp_hold%0d_valid", k), 64'(out_valid), 64'(1));
            tick();
        end
        chk("bp_cnt_stalled", 64'(hit_cnt), 64'(0));
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_comb", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
        chk("bp_second_x", 64'(x), 64'hFF);
        chk("bp_second_valid", 64'(out_valid), 64'(1));
        chk("bp_cnt_first", 64'(hit_cnt), 64'(3));
        tick();
        chk("bp_no_dup", 64'(out_valid), 64'(0));
        chk("bp_cnt_second", 64'(hit_cnt), 64'(11));

        // LUT write alongside in_fire uses the old table
        cfg_we = 1'b1; cfg_lut = 8'h80;
        a = 8'hFF; b = 8'hFF; c = 8'hFF; in_valid = 1'b1;
        tick();
        cfg_we = 1'b0; in_valid = 1'b0;
        chk("lutw_old_x", 64'(x), 64'h00);
        chk("lutw_readback", 64'(lut), 64'h80);
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lutw_new_x", 64'(x), 64'hFF);
        tick();

        // saturation (CNT_W=4 instance) with the 16-bit instance as reference
        program_lut(8'hFF);
        clear_cnt();
        chk("sat_clr_small", 64'(s_hit_cnt), 64'(0));
        chk("sat_clr_big", 64'(hit_cnt), 64'(0));
        a = 8'h12; b = 8'h34; c = 8'h56; in_valid = 1'b1;
        tick();
        tick();
        chk("sat1_small", 64'(s_hit_cnt), 64'(8));
        chk("sat1_big", 64'(hit_cnt), 64'(8));
        tick();
        in_valid = 1'b0;
        chk("sat2_small", 64'(s_hit_cnt), 64'(15));
        chk("sat2_big", 64'(hit_cnt), 64'(16));
        tick();
        chk("sat3_small", 64'(s_hit_cnt), 64'(15));
        chk("sat3_big", 64'(hit_cnt), 64'(24));
        chk("sat3_drained", 64'(out_valid), 64'(0));

        // clear wins over increment
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("clr_x_full", 64'(x), 64'hFF);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_prio_big", 64'(hit_cnt), 64'(0));
        chk("clr_prio_small", 64'(s_hit_cnt), 64'(0));
        chk("clr_consumed", 64'(out_valid), 64'(0));

        // reset while a result is held under backpressure
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mrst_cnt_pre", 64'(hit_cnt), 64'(8));
        out_ready = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mrst_held", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_out_valid", 64'(out_valid), 64'(0));
        chk("mrst_x", 64'(x), 64'(0));
        chk("mrst_hit_cnt", 64'(hit_cnt), 64'(0));
        chk("mrst_lut", 64'(lut), 64'h15);
        chk("mrst_in_ready", 64'(in_ready), 64'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
